mmodel_hs: RTL and testbench

//  Parametrised, latency-configurable byte-addressed memory model for simulation and bring-up.

---
 rtl/mmodel_hs.sv | 158 +++++++++++++++
 tb/tb_mmodel_hs.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mmodel_hs.sv
// Byte-addressed simulation memory with a registered fetch port and a one-outstanding
// valid/ready data port; the data response rises LATENCY clock edges after the accept edge.
module mmodel_hs #(
  parameter int          MEM_BYTES = 4096,
  parameter int          LATENCY   = 1,
  parameter string       INIT_FILE = "",
  parameter logic [31:0] BAD_VAL   = 32'hBAAD_F00D
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  output logic        imem_rvalid,
  output logic [31:0] imem_rdata,
  output logic        imem_err,
  input  logic        dmem_req_valid,
  output logic        dmem_req_ready,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_byte_en,
  output logic        dmem_resp_valid,
  input  logic        dmem_resp_ready,
  output logic [31:0] dmem_rdata,
  output logic        dmem_err
);

  localparam int          AW        = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);
  localparam logic [4:0]  CNT_LOAD  = 5'(LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  logic [7:0]    r_mem [MEM_BYTES];

  state_t        r_state, w_state_next;
  logic [4:0]    r_cnt, w_cnt_next;
  logic [31:0]   r_addr, r_wdata;
  logic [3:0]    r_be;
  logic          r_we;
  logic [31:0]   r_drdata;
  logic          r_derr;
  logic          r_irvalid, r_ierr;
  logic [31:0]   r_irdata;

  logic          w_accept, w_commit, w_derr, w_mem_wr, w_if_oor;
  logic [3:0]    w_lane_oor;
  logic [AW-1:0] w_lane_idx [4];
  logic [AW-1:0] w_if_idx   [4];
  logic [31:0]   w_rd_word, w_if_word;

  assign dmem_req_ready  = (r_state == S_IDLE);
  assign dmem_resp_valid = (r_state == S_RESP);
  assign dmem_rdata      = r_drdata;
  assign dmem_err        = r_derr;
  assign imem_rvalid     = r_irvalid;
  assign imem_rdata      = r_irdata;
  assign imem_err        = r_ierr;

  assign w_accept = dmem_req_valid && dmem_req_ready;
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 5'd0);
  assign w_derr   = |(r_be & w_lane_oor);
  assign w_mem_wr = w_commit && r_we && !w_derr;
  // 33-bit sum so a wrap past 2^32-1 lands above MEM_LIMIT and counts as out of range
  assign w_if_oor = ({1'b0, imem_addr} + 33'd3) >= MEM_LIMIT;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [32:0] w_lane_addr;
      assign w_lane_addr      = {1'b0, r_addr} + 33'(gi);
      assign w_lane_oor[gi]   = (w_lane_addr >= MEM_LIMIT);
      assign w_lane_idx[gi]   = r_addr[AW-1:0] + AW'(gi);
      assign w_if_idx[gi]     = imem_addr[AW-1:0] + AW'(gi);
      assign w_rd_word[8*gi +: 8] = (r_be[gi] && !w_derr) ? r_mem[w_lane_idx[gi]]
                                                           : BAD_VAL[8*gi +: 8];
      assign w_if_word[8*gi +: 8] = r_mem[w_if_idx[gi]];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: if (dmem_req_valid) begin
        w_state_next = S_WAIT;
        w_cnt_next   = CNT_LOAD;
      end
      S_WAIT: if (r_cnt == 5'd0) w_state_next = S_RESP;
              else               w_cnt_next   = r_cnt - 5'd1;
      S_RESP: if (dmem_resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wdata  <= '0;
      r_be     <= '0;
      r_we     <= 1'b0;
      r_drdata <= '0;
      r_derr   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= dmem_addr;
        r_wdata <= dmem_wdata;
        r_be    <= dmem_byte_en;
        r_we    <= dmem_we;
      end
      if (w_commit) begin
        r_derr   <= w_derr;
        r_drdata <= r_we ? BAD_VAL : w_rd_word;
      end
    end
  end

  // Nonblocking update means a fetch on the commit edge still sees pre-write bytes
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_wr && r_be[i]) r_mem[w_lane_idx[i]] <= r_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irvalid <= 1'b0;
      r_ierr    <= 1'b0;
      r_irdata  <= '0;
    end else if (imem_req) begin
      r_irvalid <= 1'b1;
      r_ierr    <= w_if_oor;
      r_irdata  <= w_if_oor ? BAD_VAL : w_if_word;
    end else begin
      r_irvalid <= 1'b0;
    end
  end

`ifdef BENCH
  always_ff @(posedge clk) begin
    if (rst_n && w_commit && w_derr)
      $error("mmodel_hs: data access error at addr %h be %b", r_addr, r_be);
    if (rst_n && imem_req && w_if_oor)
      $error("mmodel_hs: fetch out of range at addr %h", imem_addr);
  end
`endif

endmodule

// File: tb/tb_mmodel_hs.sv
// Randomized and directed bench for mmodel_hs; a byte-array reference model supplies
// every expected fetch/data result, response latency and error flag.
module tb_mmodel_hs;

  localparam int          MEM_BYTES = 4096;
  localparam int          LAT       = 3;
  localparam logic [31:0] BAD       = 32'hBAAD_F00D;

  logic        clk, rst_n;
  logic        imem_req, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_byte_en;
  logic        dmem_resp_valid, dmem_resp_ready, dmem_err;

  mmodel_hs #(.MEM_BYTES(MEM_BYTES), .LATENCY(LAT), .INIT_FILE(""), .BAD_VAL(BAD)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .imem_err(imem_err),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en),
    .dmem_resp_valid(dmem_resp_valid), .dmem_resp_ready(dmem_resp_ready),
    .dmem_rdata(dmem_rdata), .dmem_err(dmem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_mem [MEM_BYTES];
  logic [31:0] rd, old_word, saved;
  bit          dummy_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: any enabled lane past the end errors; disabled lanes and writes read BAD.
  function automatic void ref_data(input bit we, input logic [31:0] a, input logic [31:0] wd,
                                   input logic [3:0] be, output logic [31:0] rdv, output bit err);
    longint unsigned la;
    err = 0;
    for (int i = 0; i < 4; i++) begin
      la = longint'(a) + longint'(i);
      if (be[i] && la >= longint'(MEM_BYTES)) err = 1;
    end
    rdv = BAD;
    if (!err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          if (we) ref_mem[int'(a) + i] = wd[8*i +: 8];
          else    rdv[8*i +: 8] = ref_mem[int'(a) + i];
        end
      end
    end
    if (we) rdv = BAD;
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] a, output bit err);
    logic [31:0] w;
    err = (longint'(a) + 64'd3) >= longint'(MEM_BYTES);
    if (err) return BAD;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_mem[int'(a) + i];
    return w;
  endfunction

  task automatic do_fetch(input logic [31:0] a);
    logic [31:0] e;
    bit ee;
    e = ref_fetch(a, ee);
    imem_req  = 1'b1;
    imem_addr = a;
    @(negedge clk);
    imem_req  = 1'b0;
    check("fetch_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("fetch_err", {31'd0, imem_err}, {31'd0, ee});
    check("fetch_rdata", imem_rdata, e);
    $display("fetch  addr=%h rdata=%h err=%0d", a, imem_rdata, imem_err);
  endtask

  // Starts and ends on a falling edge; pend keeps a second request waiting through the response.
  task automatic dtxn(input bit we, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, input bit pend,
                      output logic [31:0] rd_obs);
    logic [31:0] e;
    bit ee;
    int guard, lat;
    ref_data(we, a, wd, be, e, ee);
    dmem_req_valid = 1'b1;
    dmem_we        = we;
    dmem_addr      = a;
    dmem_wdata     = wd;
    dmem_byte_en   = be;
    guard = 0;
    while (dmem_req_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("req_ready", {31'd0, dmem_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    dmem_req_valid = pend;
    dmem_we        = 1'b0;
    lat = 0;
    while (dmem_resp_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'(LAT));
    check("resp_rdata", dmem_rdata, e);
    check("resp_err", {31'd0, dmem_err}, {31'd0, ee});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {31'd0, dmem_resp_valid}, 32'd1);
      check("hold_rdata", dmem_rdata, e);
      check("hold_err", {31'd0, dmem_err}, {31'd0, ee});
      check("hold_req_ready", {31'd0, dmem_req_ready}, 32'd0);
    end
    rd_obs = dmem_rdata;
    $display("data   we=%0d addr=%h be=%b wdata=%h rdata=%h err=%0d lat=%0d",
             we, a, be, wd, dmem_rdata, dmem_err, lat);
    dmem_resp_ready = 1'b1;
    @(negedge clk);
    dmem_resp_ready = 1'b0;
    check("resp_dropped", {31'd0, dmem_resp_valid}, 32'd0);
    check("idle_after_hs", {31'd0, dmem_req_ready}, 32'd1);
    dmem_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; imem_req = 1'b0; imem_addr = '0;
    dmem_req_valid = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    dmem_byte_en = '0; dmem_resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_imem_rvalid", {31'd0, imem_rvalid}, 32'd0);
    check("rst_resp_valid", {31'd0, dmem_resp_valid}, 32'd0);
    check("rst_imem_rdata", imem_rdata, 32'd0);
    check("rst_dmem_rdata", dmem_rdata, 32'd0);
    check("rst_errs", {30'd0, imem_err, dmem_err}, 32'd0);
    check("rst_req_ready", {31'd0, dmem_req_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 'h400; a += 4) dtxn(1'b1, 32'(a), $urandom, 4'hF, 0, 1'b0, rd);
    dtxn(1'b1, 32'(MEM_BYTES - 4), $urandom, 4'hF, 0, 1'b0, rd);

    dtxn(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd);
    dtxn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b0, rd);
    check("spec_full_word", rd, 32'hDEAD_BEEF);
    dtxn(1'b1, 32'h101, 32'h0000_00AA, 4'b0001, 0, 1'b0, rd);
    dtxn(1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b0, rd);
    check("spec_partial", rd, 32'hDEAD_AAEF);
    dtxn(1'b0, 32'h100, 32'h0, 4'b0011, 0, 1'b0, rd);
    check("spec_lower_half", rd, {BAD[31:16], 16'hAAEF});
    dtxn(1'b0, 32'h100, 32'h0, 4'b0000, 0, 1'b0, rd);
    check("spec_be_zero", rd, BAD);

    dtxn(1'b0, 32'(MEM_BYTES - 2), 32'h0, 4'hF, 0, 1'b0, rd);
    check("spec_oor_read", rd, BAD);
    dtxn(1'b1, 32'(MEM_BYTES - 2), 32'h5555_5555, 4'hF, 0, 1'b0, rd);
    dtxn(1'b0, 32'(MEM_BYTES - 4), 32'h0, 4'hF, 0, 1'b0, rd);
    dtxn(1'b0, 32'hFFFF_FFFE, 32'h0, 4'b1100, 0, 1'b0, rd);

    dtxn(1'b0, 32'h104, 32'h0, 4'hF, 5, 1'b1, rd);

    // Fetch @0x40 lands on the same edge that commits the write to 0x40
    old_word = ref_fetch(32'h40, dummy_err);
    dmem_req_valid = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h40;
    dmem_wdata = 32'h1122_3344; dmem_byte_en = 4'hF;
    check("coll_req_ready", {31'd0, dmem_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    dmem_req_valid = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    imem_req = 1'b1; imem_addr = 32'h40;
    @(negedge clk);
    imem_req = 1'b0;
    check("coll_fetch_rvalid", {31'd0, imem_rvalid}, 32'd1);
    check("coll_fetch_old", imem_rdata, old_word);
    check("coll_resp_valid", {31'd0, dmem_resp_valid}, 32'd1);
    ref_data(1'b1, 32'h40, 32'h1122_3344, 4'hF, rd, dummy_err);
    check("coll_resp_err", {31'd0, dmem_err}, 32'd0);
    $display("data   we=1 addr=00000040 collided fetch rdata=%h", imem_rdata);
    dmem_resp_ready = 1'b1;
    @(negedge clk);
    dmem_resp_ready = 1'b0;
    do_fetch(32'h40);
    check("coll_fetch_new", imem_rdata, 32'h1122_3344);
    saved = imem_rdata;
    @(negedge clk);
    check("fetch_idle_rvalid", {31'd0, imem_rvalid}, 32'd0);
    check("fetch_idle_hold", imem_rdata, saved);

    // Reset while a write to 0x80 is still waiting to commit
    do_fetch(32'h84);
    old_word = ref_fetch(32'h80, dummy_err);
    dmem_req_valid = 1'b1; dmem_we = 1'b1; dmem_addr = 32'h80;
    dmem_wdata = ~old_word; dmem_byte_en = 4'hF;
    check("rstw_req_ready", {31'd0, dmem_req_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    dmem_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstw_resp_valid", {31'd0, dmem_resp_valid}, 32'd0);
    check("rstw_req_ready_idle", {31'd0, dmem_req_ready}, 32'd1);
    check("rstw_imem_rdata", imem_rdata, 32'd0);
    check("rstw_dmem_rdata", dmem_rdata, 32'd0);
    check("rstw_errs", {30'd0, imem_err, dmem_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dtxn(1'b0, 32'h80, 32'h0, 4'hF, 0, 1'b0, rd);
    check("rstw_word_kept", rd, old_word);

    for (int it = 0; it < 300; it++) begin
      int sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 8)       a = 32'($urandom_range(0, 'h3FC));
      else if (sel == 8) a = 32'(MEM_BYTES - 4 + $urandom_range(0, 6));
      else               a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) do_fetch(a);
      else dtxn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)), rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
